// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker fetch path.
package tinker_pkg;

    localparam logic [63:0] TINKER_RESET_PC = 64'h2000;
    localparam int          INST_W          = 32;
    localparam int          ADDR_W          = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetchq_state_t;

endpackage

// File: rtl/tinker_inst_fifo.sv
// Synchronous FIFO of {pc, inst} entries with push, pop, occupancy count and clear.
module tinker_inst_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 96,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !clear;
        do_pop   = pop && !clear && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        do_push |-> (count_q < CW'(DEPTH)))
        else $error("inst fifo push while full");

endmodule

// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order response buffering, redirect flush, halt.
// Optional performance counters are enabled by defining TINKER_FETCHQ_PERF_EN.
module tinker_fetch_queue
    import tinker_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = TINKER_RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              hlt,
    output logic              halted
`ifdef TINKER_FETCHQ_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    fetchq_state_t            state_q, state_d;
    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]        rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic [CW-1:0]            drop_q, drop_d;
    logic [CW-1:0]            fifo_count;
    logic [CW:0]              occupancy;
    logic                     fifo_push, fifo_pop, fifo_clear;
    logic                     req_fire;
    logic [ADDR_W+INST_W-1:0] fifo_rdata;

    // In-flight requests reserve a slot, so a returning word always has room.
    assign occupancy     = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign mem_req_valid = reset_n && (state_q == RUN) && (occupancy < DEPTH_C);
    assign mem_req_addr  = fetch_pc_q;
    assign inst_valid    = (fifo_count != '0);
    assign inst_pc       = fifo_rdata[ADDR_W+INST_W-1 -: ADDR_W];
    assign inst_data     = fifo_rdata[INST_W-1:0];
    assign halted        = (state_q == HALT);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;
        fifo_pop   = inst_valid && inst_ready;
        req_fire   = mem_req_valid && mem_req_ready;

        if (hlt) begin
            state_d    = HALT;
            fifo_clear = 1'b1;
            inflight_d = '0;
            drop_d     = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        fifo_clear = 1'b1;
                        fetch_pc_d = redirect_pc;
                        rsp_pc_d   = redirect_pc;
                        drop_d     = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);
                        inflight_d = '0;
                        if (drop_d != '0) state_d = FLUSH;
                    end else begin
                        if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
                        if (mem_rsp_valid) begin
                            fifo_push = 1'b1;
                            rsp_pc_d  = rsp_pc_q + 64'd4;
                        end
                        inflight_d = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                        rsp_pc_d   = redirect_pc;
                    end
                    if (mem_rsp_valid) begin
                        drop_d = drop_q - 1'b1;
                        if (drop_d == '0) state_d = RUN;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    tinker_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (fifo_clear),
        .wdata   ({rsp_pc_q, mem_rsp_data}),
        .rdata   (fifo_rdata),
        .count   (fifo_count)
    );

`ifdef TINKER_FETCHQ_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
    logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;
    logic        perf_live;

    // A response is discarded when it lands in a flush, redirect or halt cycle.
    always_comb begin
        perf_live        = (state_q != HALT);
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        perf_drop_cnt_d  = perf_drop_cnt_q;
        if (perf_live && req_fire && (perf_fetch_cnt_q != '1))
            perf_fetch_cnt_d = perf_fetch_cnt_q + 1'b1;
        if (perf_live && redirect_valid && !hlt && (perf_flush_cnt_q != '1))
            perf_flush_cnt_d = perf_flush_cnt_q + 1'b1;
        if (perf_live && mem_rsp_valid && (hlt || redirect_valid || state_q == FLUSH)
            && (perf_drop_cnt_q != '1))
            perf_drop_cnt_d = perf_drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
            perf_drop_cnt_q  <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
            perf_drop_cnt_q  <= perf_drop_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
    assign perf_drop_cnt  = perf_drop_cnt_q;
`endif

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Scoreboard bench for tinker_fetch_queue: memory model, expected-pc queue, decoupled monitor.
module tb_tinker_fetch_queue;
    import tinker_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mem_req_valid, mem_req_ready = 1'b0;
    logic [63:0]       mem_req_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [31:0]       mem_rsp_data = '0;
    logic              inst_valid, inst_ready = 1'b1;
    logic [31:0]       inst_data;
    logic [63:0]       inst_pc;
    logic              redirect_valid = 1'b0;
    logic [63:0]       redirect_pc = '0;
    logic              hlt = 1'b0;
    logic              halted;
`ifdef TINKER_FETCHQ_PERF_EN
    logic [31:0]       perf_fetch_cnt, perf_flush_cnt, perf_drop_cnt;
    logic [31:0]       perf_drop_snap, perf_fetch_snap;
`endif

    always #5 clk = ~clk;

    tinker_fetch_queue #(.DEPTH(4), .RESET_PC(64'h2000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hlt            (hlt),
        .halted         (halted)
`ifdef TINKER_FETCHQ_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int budget = 0;
    int mem_lat = 1;
    int acc_cnt = 0;
    bit rand_ready = 1'b0;
    bit chk_stream = 1'b0;
    logic [63:0] exp_addr = '0;
    int hs_first = -1;
    int hs_last = -1;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;
    pend_t       pend[$];
    logic [63:0] expq[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0] ^ 16'hC35A, a[15:0]};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (expq.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (expq.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d words still expected, expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic wait_accepts(input int target);
        int n = 0;
        while (acc_cnt < target && n < 30) begin
            @(negedge clk);
            n++;
        end
        check64("accept_wait", 64'(acc_cnt), 64'(target));
    endtask

    // Memory model: in-order, fixed latency, accepts while budget remains.
    initial begin
        pend_t p;
        bit    rdy;
        bit    prev_stall = 1'b0;
        logic [63:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                pend.delete();
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
                prev_stall    = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    p = pend.pop_front();
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(p.addr);
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = '0;
                end
                rdy = (budget > 0) && (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
                mem_req_ready = rdy;
                if (chk_stream && prev_stall) begin
                    n_checks++;
                    if (!mem_req_valid || mem_req_addr !== prev_addr) begin
                        n_errors++;
                        $display("FAIL req_hold: valid=%0b addr=%h, expected valid=1 addr=%h",
                                 mem_req_valid, mem_req_addr, prev_addr);
                    end
                end
                if (mem_req_valid && rdy) begin
                    pend.push_back('{addr: mem_req_addr, due: cyc + mem_lat});
                    budget--;
                    acc_cnt++;
                    if (chk_stream) begin
                        check64("req_stream_addr", mem_req_addr, exp_addr);
                        exp_addr = exp_addr + 64'd4;
                    end
                end
                prev_stall = mem_req_valid && !rdy;
                prev_addr  = mem_req_addr;
            end
        end
    end

    // Monitor: every decoder handshake pops and checks the next expected word.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && inst_valid && inst_ready) begin
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                if (expq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_inst: got pc %h, expected no word", inst_pc);
                end else begin
                    e = expq.pop_front();
                    check64("inst_pc", inst_pc, e);
                    check64("inst_data", 64'(inst_data), 64'(mem_word(e)));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int a0;

        // Reset values, then streaming at one word per cycle.
        @(negedge clk);
        #3;
        check64("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check64("rst_req_addr", mem_req_addr, 64'h2000);
        check64("rst_inst_valid", 64'(inst_valid), 64'd0);
        for (int i = 0; i < 8; i++) expq.push_back(64'h2000 + 64'(4 * i));
        budget = 8;
        @(negedge clk);
        reset_n = 1'b1;
        #3;
        check64("first_req_valid", 64'(mem_req_valid), 64'd1);
        check64("first_req_addr", mem_req_addr, 64'h2000);
        repeat (2) @(negedge clk);
        #3;
        check64("cycle2_inst_valid", 64'(inst_valid), 64'd1);
        check64("cycle2_inst_pc", inst_pc, 64'h2000);
        wait_drain(40);
        check64("full_rate_span", 64'(hs_last - hs_first), 64'd7);

        // Decoder stall: the queue fills with exactly DEPTH requests.
        @(negedge clk);
        inst_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) expq.push_back(64'h2020 + 64'(4 * i));
        budget = 100;
        repeat (10) @(negedge clk);
        #3;
        check64("stall_accepts", 64'(acc_cnt - a0), 64'd4);
        check64("stall_req_valid", 64'(mem_req_valid), 64'd0);
        check64("stall_head_pc", inst_pc, 64'h2020);
        @(negedge clk);
        budget = 0;
        inst_ready = 1'b1;
        wait_drain(20);

        // Redirect with two requests in flight.
        @(negedge clk);
        mem_lat = 3;
        a0 = acc_cnt;
        budget = 2;
        wait_accepts(a0 + 2);
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check64("flush_req_valid_a", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        #3;
        check64("flush_req_valid_b", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        #3;
        check64("post_flush_req_valid", 64'(mem_req_valid), 64'd1);
        check64("post_flush_req_addr", mem_req_addr, 64'h3000);
        expq.push_back(64'h3000);
        expq.push_back(64'h3004);
        budget = 2;
        wait_drain(30);
`ifdef TINKER_FETCHQ_PERF_EN
        check64("perf_drop_after_flush", 64'(perf_drop_cnt), 64'd2);
        check64("perf_flush_after_flush", 64'(perf_flush_cnt), 64'd1);
`endif

        // Redirect coinciding with a response and a decoder handshake.
        @(negedge clk);
        mem_lat = 1;
        expq.push_back(64'h3008);
        budget = 2;
        viol = 0;
        while (!inst_valid && viol < 20) begin
            @(negedge clk);
            viol++;
        end
        check64("redir_cycle_head", inst_pc, 64'h3008);
        redirect_valid = 1'b1;
        redirect_pc = 64'h4000;
        expq.push_back(64'h4000);
        expq.push_back(64'h4004);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check64("redir_next_req_valid", 64'(mem_req_valid), 64'd1);
        check64("redir_next_req_addr", mem_req_addr, 64'h4000);
        check64("redir_no_stale", 64'(inst_valid), 64'd0);
        budget = 2;
        wait_drain(30);
`ifdef TINKER_FETCHQ_PERF_EN
        check64("perf_drop_after_redir", 64'(perf_drop_cnt), 64'd3);
        check64("perf_flush_after_redir", 64'(perf_flush_cnt), 64'd2);
`endif

        // Random backpressure from memory and decoder.
        @(negedge clk);
        exp_addr = 64'h4008;
        chk_stream = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) expq.push_back(64'h4008 + 64'(4 * i));
        budget = 12;
        viol = 0;
        while (expq.size() != 0 && viol < 400) begin
            @(negedge clk);
            inst_ready = 1'($urandom_range(0, 1));
            viol++;
        end
        wait_drain(0);
        @(negedge clk);
        inst_ready = 1'b1;
        rand_ready = 1'b0;
        chk_stream = 1'b0;

        // Halt while flushing.
        @(negedge clk);
        mem_lat = 3;
        a0 = acc_cnt;
        budget = 2;
        wait_accepts(a0 + 2);
        redirect_valid = 1'b1;
        redirect_pc = 64'h5000;
        @(negedge clk);
        redirect_valid = 1'b0;
        hlt = 1'b1;
        @(negedge clk);
        hlt = 1'b0;
        #3;
        check64("halted_rise", 64'(halted), 64'd1);
        check64("halt_req_valid", 64'(mem_req_valid), 64'd0);
`ifdef TINKER_FETCHQ_PERF_EN
        perf_drop_snap  = perf_drop_cnt;
        perf_fetch_snap = perf_fetch_cnt;
        check64("perf_fetch_total", 64'(perf_fetch_cnt), 64'(acc_cnt));
`endif
        a0 = acc_cnt;
        budget = 5;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            #3;
            if (mem_req_valid || inst_valid || !halted) viol++;
        end
        check64("halt_quiet_cycles", 64'(viol), 64'd0);
        check64("halt_no_accepts", 64'(acc_cnt), 64'(a0));
`ifdef TINKER_FETCHQ_PERF_EN
        check64("perf_drop_frozen", 64'(perf_drop_cnt), 64'(perf_drop_snap));
        check64("perf_fetch_frozen", 64'(perf_fetch_cnt), 64'(perf_fetch_snap));
`endif

        // Reset mid-run, then restart at the reset pc.
        @(negedge clk);
        reset_n = 1'b0;
        #3;
        check64("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
        check64("mid_rst_req_addr", mem_req_addr, 64'h2000);
        check64("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        check64("mid_rst_inst_data", 64'(inst_data), 64'd0);
        check64("mid_rst_inst_pc", inst_pc, 64'd0);
        check64("mid_rst_halted", 64'(halted), 64'd0);
`ifdef TINKER_FETCHQ_PERF_EN
        check64("mid_rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        check64("mid_rst_perf_flush", 64'(perf_flush_cnt), 64'd0);
        check64("mid_rst_perf_drop", 64'(perf_drop_cnt), 64'd0);
`endif
        @(negedge clk);
        budget = 2;
        mem_lat = 1;
        expq.delete();
        expq.push_back(64'h2000);
        expq.push_back(64'h2004);
        @(negedge clk);
        reset_n = 1'b1;
        #3;
        check64("restart_req_valid", 64'(mem_req_valid), 64'd1);
        check64("restart_req_addr", mem_req_addr, 64'h2000);
        wait_drain(20);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
